// File: rtl/conv_pkg.sv
// Shared definitions for the convolution memory host: word/array geometry,
// layer select codes and the host FSM state encoding.
package conv_pkg;

    localparam int unsigned PIX_W     = 20;    // 4.16 fixed point, never interpreted
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned L1_AW     = 10;
    localparam int unsigned IMG_DEPTH = 4096;
    localparam int unsigned L0_DEPTH  = 4096;
    localparam int unsigned L1_DEPTH  = 1024;
    localparam int unsigned ERR_W     = 8;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DUMP0,
        ST_DUMP1,
        ST_FIN
    } state_t;

endpackage

// File: rtl/conv_mem_ram.sv
// Simple RAM: one write port, one asynchronous read port, one registered read
// port with enable (registered data held while sren=0, cleared by reset).
//   clk, rst_n         clock, async active-low reset (read register only)
//   we/waddr/wdata     write port, lands at rising edge
//   araddr/ardata      zero-latency read (returns old data on same-cycle write)
//   sren/sraddr/srdata registered read
module conv_mem_ram #(
    parameter  int unsigned DEPTH = 4096,
    parameter  int unsigned WIDTH = 20,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    araddr,
    output logic [WIDTH-1:0] ardata,
    input  logic             sren,
    input  logic [AW-1:0]    sraddr,
    output logic [WIDTH-1:0] srdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: no reset, contents survive a host reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ardata = mem[araddr];

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srdata <= '0;
        end else if (sren) begin
            srdata <= mem[sraddr];
        end
    end

endmodule

// File: rtl/conv_mem_host.sv
// Convolution memory host: loads an image, serves it to the convolution engine,
// captures layer0/layer1 results and streams them back.
// Ports:
//   clk, reset                      clock, async active-low reset
//   ld_valid/ld_data/ld_ready       image load stream
//   ready/busy                      start request / engine running
//   iaddr/idata                     image read (combinational)
//   cwr/caddr_wr/cdata_wr           result write (RUN only)
//   crd/caddr_rd/cdata_rd/csel      result read (combinational), layer select
//   rb_valid/rb_data/rb_last/rb_ready  result readback stream
//   done, err_cnt                   finished flag, protocol error counter
// Build option: define CONV_MEM_CHK_EN to include the protocol checker that
// drives err_cnt; otherwise err_cnt is tied to 0.
module conv_mem_host
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [PIX_W-1:0]  ld_data,
    output logic              ld_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [PIX_W-1:0]  idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [PIX_W-1:0]  cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [PIX_W-1:0]  cdata_rd,
    input  logic [2:0]        csel,
    output logic              rb_valid,
    output logic [PIX_W-1:0]  rb_data,
    output logic              rb_last,
    input  logic              rb_ready,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   ld_cnt, ld_cnt_d;
    logic [ADDR_W-1:0]   ptr, ptr_d;
    logic [ADDR_W-1:0]   last_addr;
    logic                rb_valid_d, rb_last_d;
    logic                img_we, fetch;
    logic [PIX_W-1:0]    l0_ard, l1_ard, l0_srd, l1_srd, img_srd_unused;

    // Next-state, counters and stream control
    always_comb begin
        state_d    = state;
        ld_cnt_d   = ld_cnt;
        ptr_d      = ptr;
        rb_valid_d = rb_valid;
        rb_last_d  = rb_last;
        img_we     = 1'b0;
        fetch      = 1'b0;
        last_addr  = (state == ST_DUMP0) ? ADDR_W'(L0_DEPTH - 1) : ADDR_W'(L1_DEPTH - 1);
        unique case (state)
            ST_LOAD: begin
                if (ld_valid && ld_ready) begin
                    img_we   = 1'b1;
                    ld_cnt_d = ld_cnt + 1'b1;
                    if (ld_cnt == ADDR_W'(IMG_DEPTH - 1)) begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    state_d = ST_DUMP0;
                    ptr_d   = '0;
                end
            end
            ST_DUMP0, ST_DUMP1: begin
                if (rb_valid && rb_ready && rb_last) begin
                    rb_valid_d = 1'b0;
                    rb_last_d  = 1'b0;
                    ptr_d      = '0;
                    state_d    = (state == ST_DUMP0) ? ST_DUMP1 : ST_FIN;
                end else if (!rb_valid || rb_ready) begin
                    // Output slot empty or being consumed: refill from RAM
                    fetch      = 1'b1;
                    ptr_d      = ptr + 1'b1;
                    rb_valid_d = 1'b1;
                    rb_last_d  = (ptr == last_addr);
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LOAD;
            ld_cnt   <= '0;
            ptr      <= '0;
            ld_ready <= 1'b0;
            ready    <= 1'b0;
            rb_valid <= 1'b0;
            rb_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            ld_cnt   <= ld_cnt_d;
            ptr      <= ptr_d;
            ld_ready <= (state_d == ST_LOAD);
            ready    <= (state_d == ST_ARM);
            rb_valid <= rb_valid_d;
            rb_last  <= rb_last_d;
            done     <= (state_d == ST_FIN);
        end
    end

    conv_mem_ram #(.DEPTH(IMG_DEPTH), .WIDTH(PIX_W)) u_img (
        .clk(clk), .rst_n(reset),
        .we(img_we), .waddr(ld_cnt), .wdata(ld_data),
        .araddr(iaddr), .ardata(idata),
        .sren(1'b0), .sraddr('0), .srdata(img_srd_unused)
    );

    conv_mem_ram #(.DEPTH(L0_DEPTH), .WIDTH(PIX_W)) u_l0 (
        .clk(clk), .rst_n(reset),
        .we((state == ST_RUN) && cwr && (csel == CSEL_L0)),
        .waddr(caddr_wr), .wdata(cdata_wr),
        .araddr(caddr_rd), .ardata(l0_ard),
        .sren(fetch && (state == ST_DUMP0)), .sraddr(ptr), .srdata(l0_srd)
    );

    conv_mem_ram #(.DEPTH(L1_DEPTH), .WIDTH(PIX_W)) u_l1 (
        .clk(clk), .rst_n(reset),
        .we((state == ST_RUN) && cwr && (csel == CSEL_L1)),
        .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
        .araddr(caddr_rd[L1_AW-1:0]), .ardata(l1_ard),
        .sren(fetch && (state == ST_DUMP1)), .sraddr(ptr[L1_AW-1:0]), .srdata(l1_srd)
    );

    // Readback data comes straight from the active RAM's read register
    assign rb_data = ((state == ST_DUMP1) || (state == ST_FIN)) ? l1_srd : l0_srd;

    // Engine result read, gated by crd
    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel == CSEL_L0) begin
                cdata_rd = l0_ard;
            end else if (csel == CSEL_L1) begin
                cdata_rd = l1_ard;
            end
        end
    end

`ifdef CONV_MEM_CHK_EN
    logic viol;

    // Any protocol violation this cycle counts once
    always_comb begin
        viol = (cwr && crd)
            || ((cwr || crd) && (csel != CSEL_L0) && (csel != CSEL_L1))
            || ((csel == CSEL_L1) && ((cwr && (caddr_wr[ADDR_W-1:L1_AW] != '0))
                                   || (crd && (caddr_rd[ADDR_W-1:L1_AW] != '0))))
            || ((cwr || crd) && (state != ST_RUN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (viol && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: load, arm/run handshake, result
// write/read, full readback of both layers with back-pressure, reset abort.
module tb_conv_mem_host;
    import conv_pkg::*;

`ifdef CONV_MEM_CHK_EN
    localparam int unsigned EXP_ERR_RUN = 4;
    localparam int unsigned EXP_ERR_END = 5;
`else
    localparam int unsigned EXP_ERR_RUN = 0;
    localparam int unsigned EXP_ERR_END = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid, ld_ready, ready, busy;
    logic [PIX_W-1:0]  ld_data, idata, cdata_wr, cdata_rd, rb_data;
    logic [ADDR_W-1:0] iaddr, caddr_wr, caddr_rd;
    logic              cwr, crd, rb_valid, rb_last, rb_ready, done;
    logic [2:0]        csel;
    logic [ERR_W-1:0]  err_cnt;

    logic [PIX_W-1:0]  exp_l0 [L0_DEPTH];
    logic [PIX_W-1:0]  exp_l1 [L1_DEPTH];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_mem_host dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .rb_valid(rb_valid), .rb_data(rb_data), .rb_last(rb_last), .rb_ready(rb_ready),
        .done(done), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stream IMG[k]=k with ld_valid held high; returns words accepted
    task automatic load_image(output int n_acc);
        int   k = 0;
        logic acc;
        ld_valid = 1'b1;
        ld_data  = 20'(k);
        for (int cyc = 0; cyc < 5000 && k < 4096; cyc++) begin
            acc = ld_ready;
            tick;
            if (acc) k++;
            ld_data = 20'(k);
        end
        n_acc = k;
    endtask

    // Receive n words with rb_ready toggling, tallying errors
    task automatic drain(input int n, input bit is_l0, output int got_n,
                         output int bad_data, output int bad_last, output int bad_hold);
        logic             rdy = 1'b0;
        logic             held_v = 1'b0;
        logic [PIX_W-1:0] held = '0;
        logic [PIX_W-1:0] expv;
        got_n = 0; bad_data = 0; bad_last = 0; bad_hold = 0;
        for (int cyc = 0; cyc < 3 * n + 20 && got_n < n; cyc++) begin
            if (held_v && (rb_valid !== 1'b1 || rb_data !== held)) bad_hold++;
            held_v   = 1'b0;
            rdy      = ~rdy;
            rb_ready = rdy;
            if (rb_valid === 1'b1) begin
                if (rdy) begin
                    expv = is_l0 ? exp_l0[got_n] : exp_l1[got_n];
                    if (rb_data !== expv) bad_data++;
                    if (rb_last !== (got_n == n - 1)) bad_last++;
                    got_n++;
                end else begin
                    held_v = 1'b1;
                    held   = rb_data;
                end
            end
            tick;
        end
        rb_ready = 1'b0;
    endtask

    initial begin
        int n, nd, nl, nh, cnt;
        reset = 1'b0; ld_valid = 1'b0; ld_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = 3'b000; rb_ready = 1'b0;
        tick; tick;

        // Reset values
        check("rst_ready", ready, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_rb_valid", rb_valid, 0);
        check("rst_rb_last", rb_last, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_done", done, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset = 1'b1;
        #1 check("ld_ready_pre_clk", ld_ready, 0);
        tick;
        check("ld_ready_post_clk", ld_ready, 1);

        // Image load
        load_image(n);
        check("load_count", n, 4096);
        check("ld_ready_drop", ld_ready, 0);
        check("ready_up", ready, 1);
        iaddr = 12'h7FF;
        #1 check("idata_7ff", idata, 20'h007FF);
        iaddr = 12'hFFF;
        #1 check("idata_fff", idata, 20'h00FFF);
        iaddr = 12'h000;
        ld_data = 20'hFFFFF;
        tick; tick;
        check("ld_ignored_arm", idata, 20'h00000);
        check("ready_hold", ready, 1);
        ld_valid = 1'b0;

        // Engine start
        busy = 1'b1;
        tick;
        check("ready_drop", ready, 0);

        // Fill both result layers
        cwr = 1'b1; csel = CSEL_L0;
        for (int a = 0; a < 4096; a++) begin
            caddr_wr = 12'(a); cdata_wr = 20'hA0000 | 20'(a); exp_l0[a] = cdata_wr;
            tick;
        end
        csel = CSEL_L1;
        for (int a = 0; a < 1024; a++) begin
            caddr_wr = 12'(a); cdata_wr = 20'hC0000 | 20'(a); exp_l1[a] = cdata_wr;
            tick;
        end
        cwr = 1'b0;

        // L1 write then read back; L0 same address untouched
        cwr = 1'b1; csel = CSEL_L1; caddr_wr = 12'h005; cdata_wr = 20'hABCDE; exp_l1[5] = 20'hABCDE;
        tick;
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h005;
        #1 check("l1_readback", cdata_rd, 20'hABCDE);
        csel = CSEL_L0;
        #1 check("l0_unchanged", cdata_rd, 20'hA0005);
        crd = 1'b0;
        #1 check("crd_gate", cdata_rd, 0);
        tick;

        // Same-address read/write returns old data (violation 1)
        cwr = 1'b1; crd = 1'b1; csel = CSEL_L0; caddr_wr = 12'h007; caddr_rd = 12'h007;
        cdata_wr = 20'h12345; exp_l0[7] = 20'h12345;
        #1 check("raw_old", cdata_rd, 20'hA0007);
        tick;
        cwr = 1'b0;
        #1 check("raw_new", cdata_rd, 20'h12345);

        // Two more simultaneous read/write cycles (violations 2, 3)
        cwr = 1'b1; csel = CSEL_L1; caddr_wr = 12'h008; cdata_wr = 20'h11111; caddr_rd = 12'h009;
        exp_l1[8] = 20'h11111;
        #1 check("l1_rd9", cdata_rd, 20'hC0009);
        tick;
        csel = CSEL_L0; caddr_wr = 12'h00A; cdata_wr = 20'h22222; caddr_rd = 12'h00A;
        exp_l0[10] = 20'h22222;
        #1 check("raw_old2", cdata_rd, 20'hA000A);
        tick;

        // Write with invalid layer select (violation 4)
        crd = 1'b0; cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h009; cdata_wr = 20'h33333;
        tick;
        cwr = 1'b0; crd = 1'b1; csel = CSEL_L0; caddr_rd = 12'h009;
        #1 check("csel010_l0", cdata_rd, 20'hA0009);
        csel = CSEL_L1;
        #1 check("csel010_l1", cdata_rd, 20'hC0009);
        check("err_cnt_run", err_cnt, EXP_ERR_RUN);
        check("rb_valid_run", rb_valid, 0);
        crd = 1'b0; csel = 3'b000;
        tick;

        // Engine finishes
        busy = 1'b0;
        tick;
        check("dump0_first_gap", rb_valid, 0);
        // Write outside RUN is ignored (violation 5)
        cwr = 1'b1; csel = CSEL_L1; caddr_wr = 12'h000; cdata_wr = 20'hFFFFF;
        tick;
        cwr = 1'b0; csel = 3'b000;
        check("dump0_first_valid", rb_valid, 1);
        check("dump0_first_data", rb_data, 20'hA0000);

        drain(4096, 1'b1, n, nd, nl, nh);
        check("dump0_count", n, 4096);
        check("dump0_data_err", nd, 0);
        check("dump0_last_err", nl, 0);
        check("dump0_hold_err", nh, 0);
        check("dump1_first_gap", rb_valid, 0);
        check("done_mid", done, 0);

        drain(1024, 1'b0, n, nd, nl, nh);
        check("dump1_count", n, 1024);
        check("dump1_data_err", nd, 0);
        check("dump1_last_err", nl, 0);
        check("dump1_hold_err", nh, 0);
        check("fin_done", done, 1);
        check("fin_rb_valid", rb_valid, 0);
        check("fin_rb_last", rb_last, 0);
        check("err_cnt_end", err_cnt, EXP_ERR_END);

        // FIN is terminal
        busy = 1'b1; ld_valid = 1'b1; rb_ready = 1'b1;
        tick; tick; tick;
        check("fin_stay_done", done, 1);
        check("fin_stay_ready", ready, 0);
        check("fin_stay_ld_ready", ld_ready, 0);
        busy = 1'b0; ld_valid = 1'b0; rb_ready = 1'b0;

        // Second run, aborted by reset in the middle of DUMP0
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        load_image(n);
        check("load2_count", n, 4096);
        ld_valid = 1'b0;
        busy = 1'b1;
        tick;
        busy = 1'b0;
        tick;
        rb_ready = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 300 && cnt < 100; cyc++) begin
            tick;
            if (rb_valid === 1'b1) cnt++;
        end
        check("abort_word_cnt", cnt, 100);
        check("abort_pre_valid", rb_valid, 1);
        reset = 1'b0;
        #1 check("abort_rb_valid", rb_valid, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 0);
        check("abort_rb_data", rb_data, 0);
        tick;
        check("abort_rb_valid_clk", rb_valid, 0);
        check("abort_ld_ready", ld_ready, 0);
        rb_ready = 1'b0;
        reset = 1'b1;
        tick;
        check("abort_ld_ready_up", ld_ready, 1);
        check("abort_ready_low", ready, 0);
        // Load restarts at IMG[0]
        ld_valid = 1'b1; ld_data = 20'h55555;
        tick;
        ld_valid = 1'b0; iaddr = 12'h000;
        #1 check("abort_reload_0", idata, 20'h55555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_mem_host.md
CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; low clears all state.
REQ-003 SHALL have ports: ld_valid in 1 load word valid; ld_data in 20 image pixel; ld_ready out 1 load word accepted.
REQ-004 SHALL have ports: ready out 1 image loaded, start request; busy in 1 convolution engine running.
REQ-005 SHALL have ports: iaddr in 12 image read address; idata out 20 image read data.
REQ-006 SHALL have ports: cwr in 1; caddr_wr in 12; cdata_wr in 20; crd in 1; caddr_rd in 12; cdata_rd out 20; csel in 3 (001 = layer0, 011 = layer1).
REQ-007 SHALL have ports: rb_valid out 1; rb_data out 20; rb_last out 1; rb_ready in 1 result readback stream; done out 1; err_cnt out 8.

Function
REQ-008 SHALL hold three arrays: IMG 4096x20, L0 4096x20, L1 1024x20; word width 20 bits, format 4 integer + 16 fraction (passed through unchanged).
REQ-009 SHALL implement FSM LOAD -> ARM -> RUN -> DUMP0 -> DUMP1 -> FIN; FIN is terminal until reset.
REQ-010 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to IMG[ld_cnt], ld_cnt increments; after write at ld_cnt=4095, next state ARM.
REQ-011 ARM: ready=1, ld_ready=0; on first cycle with busy=1, ready drops to 0 next cycle and state -> RUN.
REQ-012 RUN: on cycle where busy samples 0 (after having been 1), state -> DUMP0.
REQ-013 idata SHALL equal IMG[iaddr] combinationally in all states (zero-latency read; engine samples same cycle).
REQ-014 cdata_rd SHALL equal L0[caddr_rd] when csel=001, L1[caddr_rd[9:0]] when csel=011, else 0; combinational, gated by crd=1 (0 when crd=0).
REQ-015 Write with cwr=1 in RUN: csel=001 writes L0[caddr_wr]; csel=011 writes L1[caddr_wr[9:0]]; other csel values write nothing; writes outside RUN are ignored.
REQ-016 Read and write same address same cycle: cdata_rd returns old contents (write lands at clock edge).
REQ-017 DUMP0 streams L0[0..4095], DUMP1 streams L1[0..1023]; synchronous read, first rb_valid one cycle after entering each DUMP state.
REQ-018 Readback handshake: word transfers when rb_valid & rb_ready; rb_data and rb_valid held stable while rb_ready=0; no word skipped or repeated.
REQ-019 rb_last=1 with word L0[4095] and with word L1[1023]; after L1[1023] transfers, state -> FIN, done=1, rb_valid=0.
REQ-020 ld_valid outside LOAD, busy changes outside ARM/RUN and rb_ready outside DUMP states SHALL be ignored.

Reset
REQ-021 reset low: state LOAD, counters 0, ready=0, ld_ready=0 until first clock after release then 1, rb_valid=0, rb_last=0, rb_data=0, done=0, err_cnt=0.
REQ-022 Reset mid-operation SHALL abort immediately to LOAD; array contents not cleared and undefined for the new run.

Configuration
REQ-023 Macro CONV_MEM_CHK_EN defined: protocol checker increments err_cnt (saturating at 255) once per cycle with any of: cwr&crd, (cwr|crd) with csel not 001/011, csel=011 with address bit [11:10] nonzero, cwr|crd outside RUN.
REQ-024 CONV_MEM_CHK_EN undefined: checker absent, err_cnt tied to 0; all other behaviour identical.

Structure
REQ-025 Shared package conv_pkg SHALL hold: pixel width 20, IMG/L0 depth 4096, L1 depth 1024, csel codes 001/011, FSM state enum.
REQ-026 One sub-module conv_mem_ram (parameterised depth/width, one write port, one async read port, one sync read port) SHALL be instantiated three times.

Verification
REQ-027 Load 4096 words IMG[k]=k, hold ld_valid=1 -> ld_ready drops after word 4095, ready=1 next cycle; iaddr=0x7FF -> idata=0x007FF same cycle.
REQ-028 In ARM raise busy for 1 cycle -> ready=0 next cycle; busy low -> first rb_valid 2 cycles later with rb_data=L0[0].
REQ-029 In RUN write cwr=1 csel=011 caddr_wr=0x005 cdata_wr=0xABCDE, next cycle crd=1 csel=011 caddr_rd=0x005 -> cdata_rd=0xABCDE; L0[5] unchanged.
REQ-030 During DUMP0 toggle rb_ready every other cycle -> 4096 words in order, no duplicates, rb_last only on 4096th; DUMP1 gives 1024 words then done=1.
REQ-031 With CONV_MEM_CHK_EN: 3 cycles cwr=crd=1 plus 1 write csel=010 -> err_cnt=4, L0/L1 unchanged by csel=010 write; without macro err_cnt=0.
REQ-032 Assert reset low during DUMP0 word 100 -> next cycle rb_valid=0, done=0, ready=0, state LOAD, ld_ready=1 after release.
